dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single data-memory port between the pipeline MEM stage (core) and a host debug/loader port. The core has priority; a starvation counter guarantees debug service by stalling the core for one cycle. Sits between the MEM-stage control/address/data signals and DMEM, and drives the core stall used by the hazard/stall logic.

## Interface
- bits, 64, data width
- addr_width_DMEM, 5, DMEM word-address width
- starve_limit, 8, consecutive blocked cycles (≥1) before debug is forced in
- dbg_ctrl, 3'b011, DMEM control code used for every debug access (full-width)

Ports:
- clk  in  1  clock; everything is rising-edge
- reset  in  1  synchronous, active-high
- core_req  in  1  MEM stage wants DMEM this cycle (load or store)
- core_we  in  1  core write enable
- core_ctrl  in  3  core DMEM control code
- core_addr  in  addr_width_DMEM  core address
- core_wdata  in  bits  core store data
- core_rdata  out  bits  load data to the core (equals mem_rdata)
- core_stall  out  1  core must hold the MEM stage this cycle
- dbg_req  in  1  debug request, level; payload held stable until dbg_ack
- dbg_we  in  1  debug write enable
- dbg_addr  in  addr_width_DMEM  debug address
- dbg_wdata  in  bits  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  bits  debug read data, valid when dbg_ack=1
- mem_addr  out  addr_width_DMEM  to DMEM
- mem_we  out  1  to DMEM
- mem_ctrl  out  3  to DMEM
- mem_wdata  out  bits  to DMEM
- mem_rdata  in  bits  from DMEM, combinational with mem_addr
- busy  out  1  debug owns or is completing on the port

## Operation
- FSM states: IDLE, DBG_GRANT, DBG_ACK.
- IDLE: memory port driven from core fields; mem_we = core_we & core_req. Transition to DBG_GRANT when dbg_req=1 and (core_req=0 or starve_cnt == starve_limit−1). Otherwise stay.
- starve_cnt (width clog2(starve_limit)+1): in IDLE increments when dbg_req=1 and core_req=1 and no transition; cleared on entry to DBG_GRANT and whenever dbg_req=0.
- DBG_GRANT (exactly one cycle): mem_addr=dbg_addr, mem_we=dbg_we, mem_ctrl=dbg_ctrl, mem_wdata=dbg_wdata; core_stall=core_req; mem_rdata captured into dbg_rdata at the edge leaving the state (captured on writes too). Always → DBG_ACK.
- DBG_ACK (one cycle): dbg_ack=1; port back to core exactly as IDLE, core_stall=0. Always → IDLE. Requester drops or replaces dbg_req in the cycle after ack; a held dbg_req starts a new transaction.
- core_stall is 0 in IDLE and DBG_ACK; only a forced or opportunistic DBG_GRANT with core_req=1 stalls.
- Core and debug never both reach memory in one cycle; simultaneous writes: the granted side writes, the other's write is suppressed (core's is retried because it is stalled).
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, starve_cnt 0, dbg_ack 0, dbg_rdata 0, core_stall 0, busy 0; mem_we 0 while reset is high.
- Debug latency: request accepted in cycle N (IDLE, core idle) → DBG_GRANT in N+1 → dbg_ack in N+2. Worst case under continuous core traffic: ack at N+starve_limit+1.
- Core latency: zero added cycles except one stall cycle per forced grant.
- Reset mid-transaction: aborts, no ack issued; a DBG_GRANT write already presented that cycle is not guaranteed.
- starve_limit=1: debug is granted the first cycle it is seen even when core_req=1.

## Structure
- Shared package: FSM state encoding (IDLE/DBG_GRANT/DBG_ACK), DMEM control-code constants (incl. doubleword code used as dbg_ctrl default).
- Single module; the starvation counter is small enough to stay inline, no sub-module.

## Test plan
- Core idle, debug write addr 5 data 0xDEAD_BEEF: mem_we=1 addr 5 in cycle N+1, dbg_ack in N+2, core_stall never high; later core load addr 5 returns 0xDEAD_BEEF.
- Continuous core_req, debug read addr 3, starve_limit=8: DBG_GRANT in cycle N+8, core_stall high exactly that cycle, dbg_ack N+9 with dbg_rdata = memory[3].
- Core store and debug write both to addr 7 same cycle, core_req then drops: debug granted, core store suppressed that cycle, stalled store completes later, final memory[7] = core value.
- Back-to-back debug reads (dbg_req held): acks every 3 cycles while core idle, dbg_rdata tracks each address.
- Reset asserted during DBG_GRANT: next cycle state IDLE, dbg_ack 0, dbg_rdata 0, core_stall 0, busy 0.
- starve_limit=1 with core_req=1: debug granted in cycle after request, one stall cycle, ack following cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DMEM port arbiter: FSM state encoding and
// DMEM access-size control codes.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DBG_GRANT = 2'd1,
        DBG_ACK   = 2'd2
    } arb_state_t;

    localparam logic [2:0] DMEM_CTRL_BYTE  = 3'b000;
    localparam logic [2:0] DMEM_CTRL_HALF  = 3'b001;
    localparam logic [2:0] DMEM_CTRL_WORD  = 3'b010;
    localparam logic [2:0] DMEM_CTRL_DWORD = 3'b011;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single DMEM port between the MEM stage (priority) and a debug
// port; a starvation counter forces a one-cycle debug grant under core load.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned bits            = 64,
    parameter int unsigned addr_width_DMEM = 5,
    parameter int unsigned starve_limit    = 8,
    parameter logic [2:0]  dbg_ctrl        = DMEM_CTRL_DWORD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       core_req,
    input  logic                       core_we,
    input  logic [2:0]                 core_ctrl,
    input  logic [addr_width_DMEM-1:0] core_addr,
    input  logic [bits-1:0]            core_wdata,
    output logic [bits-1:0]            core_rdata,
    output logic                       core_stall,
    input  logic                       dbg_req,
    input  logic                       dbg_we,
    input  logic [addr_width_DMEM-1:0] dbg_addr,
    input  logic [bits-1:0]            dbg_wdata,
    output logic                       dbg_ack,
    output logic [bits-1:0]            dbg_rdata,
    output logic [addr_width_DMEM-1:0] mem_addr,
    output logic                       mem_we,
    output logic [2:0]                 mem_ctrl,
    output logic [bits-1:0]            mem_wdata,
    input  logic [bits-1:0]            mem_rdata,
    output logic                       busy
);

    localparam int unsigned      CNT_W    = $clog2(starve_limit) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(starve_limit - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [bits-1:0]  r_dbg_rdata;
    logic             w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counts cycles debug waited behind the core; never exceeds CNT_LAST
    // because reaching it forces the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (!dbg_req || w_grant) begin
                r_starve_cnt <= '0;
            end else if (core_req) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_rdata <= '0;
        end else if (r_state == DBG_GRANT) begin
            r_dbg_rdata <= mem_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        mem_addr    = core_addr;
        mem_we      = core_we & core_req;
        mem_ctrl    = core_ctrl;
        mem_wdata   = core_wdata;
        core_stall  = 1'b0;
        dbg_ack     = 1'b0;

        case (r_state)
            IDLE: begin
                w_grant = dbg_req && (!core_req || (r_starve_cnt == CNT_LAST));
                if (w_grant) begin
                    w_state_nxt = DBG_GRANT;
                end
            end
            DBG_GRANT: begin
                mem_addr    = dbg_addr;
                mem_we      = dbg_we;
                mem_ctrl    = dbg_ctrl;
                mem_wdata   = dbg_wdata;
                core_stall  = core_req;
                w_state_nxt = DBG_ACK;
            end
            DBG_ACK: begin
                dbg_ack     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Reset aborts whatever is in flight: no write, stall or ack escapes.
        if (reset) begin
            mem_we     = 1'b0;
            core_stall = 1'b0;
            dbg_ack    = 1'b0;
        end
    end

    assign core_rdata = mem_rdata;
    assign dbg_rdata  = r_dbg_rdata;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: hand sequences for the debug protocol,
// an IDLE pass-through vector table, and a scoreboard on debug acks.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int BITS = 64;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset      = 1'b1;
    logic            core_req   = 1'b0;
    logic            core_we    = 1'b0;
    logic [2:0]      core_ctrl  = 3'b000;
    logic [AW-1:0]   core_addr  = '0;
    logic [BITS-1:0] core_wdata = '0;
    logic            dbg_req    = 1'b0;
    logic            dbg_we     = 1'b0;
    logic [AW-1:0]   dbg_addr   = '0;
    logic [BITS-1:0] dbg_wdata  = '0;

    logic [BITS-1:0] a_core_rdata, a_dbg_rdata, a_mem_wdata, a_mem_rdata;
    logic            a_core_stall, a_dbg_ack, a_mem_we, a_busy;
    logic [AW-1:0]   a_mem_addr;
    logic [2:0]      a_mem_ctrl;
    logic [BITS-1:0] b_core_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
    logic            b_core_stall, b_dbg_ack, b_mem_we, b_busy;
    logic [AW-1:0]   b_mem_addr;
    logic [2:0]      b_mem_ctrl;

    logic [BITS-1:0] mem_a [32];
    logic [BITS-1:0] mem_b [32];

    dmem_arbiter #(.bits(BITS), .addr_width_DMEM(AW), .starve_limit(8), .dbg_ctrl(3'b011)) u_a (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_ctrl(core_ctrl),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(a_core_rdata), .core_stall(a_core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_ctrl(a_mem_ctrl),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    dmem_arbiter #(.bits(BITS), .addr_width_DMEM(AW), .starve_limit(1), .dbg_ctrl(3'b011)) u_b (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_ctrl(core_ctrl),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(b_core_rdata), .core_stall(b_core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_ctrl(b_mem_ctrl),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [BITS-1:0] pat(input logic [AW-1:0] a);
        return 64'hA5A5_5A5A_0000_0000 + 64'(a) * 64'h0000_0000_0101_0101;
    endfunction

    // DMEM models: preloaded with pat() while reset is high, combinational read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] <= pat(AW'(i));
                mem_b[i] <= pat(AW'(i));
            end
        end else begin
            if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
            if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        end
    end
    assign a_mem_rdata = mem_a[a_mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    typedef struct {
        string           name;
        logic [BITS-1:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        if (!reset && a_dbg_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ack: got dbg_ack=1 expected no ack");
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk(e.name, a_dbg_rdata, e.rdata);
            end
        end
    end

    typedef struct {
        logic            req;
        logic            we;
        logic [2:0]      ctrl;
        logic [AW-1:0]   addr;
        logic [BITS-1:0] wdata;
        logic            exp_we;
        logic [BITS-1:0] exp_rdata;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 3'b011, 5'd12, 64'h0000_0000_0000_1234, 1'b1, pat(5'd12)};
        vecs[1] = '{1'b1, 1'b0, 3'b010, 5'd12, 64'h0,                   1'b0, 64'h0000_0000_0000_1234};
        vecs[2] = '{1'b0, 1'b1, 3'b000, 5'd13, 64'h0000_0000_0000_FFFF, 1'b0, pat(5'd13)};
        vecs[3] = '{1'b1, 1'b0, 3'b001, 5'd13, 64'h0,                   1'b0, pat(5'd13)};
        vecs[4] = '{1'b1, 1'b1, 3'b001, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, pat(5'd31)};
        vecs[5] = '{1'b1, 1'b0, 3'b011, 5'd31, 64'h0,                   1'b0, 64'hFFFF_FFFF_FFFF_FFFF};

        // Reset: write request from the core must not reach memory.
        core_req = 1'b1; core_we = 1'b1;
        next_cycle(); next_cycle(); settle();
        chk("rst_mem_we", 64'(a_mem_we), 64'd0);
        next_cycle();
        reset = 1'b0; core_req = 1'b0; core_we = 1'b0;
        settle();
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_ack", 64'(a_dbg_ack), 64'd0);
        chk("rst_rdata", a_dbg_rdata, 64'd0);
        chk("rst_stall", 64'(a_core_stall), 64'd0);

        // Debug write while core idle: grant at N+1, ack at N+2.
        next_cycle();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 64'h0000_0000_DEAD_BEEF;
        sb_q.push_back('{"t1_wr_rdata", pat(5'd5)});
        settle();
        chk("t1_n_busy", 64'(a_busy), 64'd0);
        next_cycle(); settle();
        chk("t1_grant_we", 64'(a_mem_we), 64'd1);
        chk("t1_grant_addr", 64'(a_mem_addr), 64'd5);
        chk("t1_grant_wdata", a_mem_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("t1_grant_stall", 64'(a_core_stall), 64'd0);
        chk("t1_grant_ack", 64'(a_dbg_ack), 64'd0);
        next_cycle(); settle();
        chk("t1_ack", 64'(a_dbg_ack), 64'd1);
        chk("t1_ack_stall", 64'(a_core_stall), 64'd0);
        next_cycle();
        dbg_req = 1'b0; dbg_we = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 5'd5;
        settle();
        chk("t1_core_load", a_core_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("t1_idle_busy", 64'(a_busy), 64'd0);

        // Continuous core loads, debug read addr 3: forced grant at N+8.
        next_cycle();
        core_req = 1'b1; core_we = 1'b0; core_addr = 5'd10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        sb_q.push_back('{"t2_rd_rdata", pat(5'd3)});
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("t2_wait%0d_stall", k), 64'(a_core_stall), 64'd0);
            chk($sformatf("t2_wait%0d_busy", k), 64'(a_busy), 64'd0);
            next_cycle();
        end
        settle();
        chk("t2_grant_stall", 64'(a_core_stall), 64'd1);
        chk("t2_grant_addr", 64'(a_mem_addr), 64'd3);
        chk("t2_grant_ctrl", 64'(a_mem_ctrl), 64'd3);
        next_cycle(); settle();
        chk("t2_ack", 64'(a_dbg_ack), 64'd1);
        chk("t2_ack_stall", 64'(a_core_stall), 64'd0);
        chk("t2_ack_addr", 64'(a_mem_addr), 64'd10);
        next_cycle();
        dbg_req = 1'b0; core_req = 1'b0;

        // Core store and debug write to addr 7: forced grant wins, core retries.
        next_cycle();
        core_req = 1'b1; core_we = 1'b1; core_addr = 5'd7; core_wdata = 64'h0000_0000_0000_C0DE;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 64'h0000_0000_0000_D00D;
        sb_q.push_back('{"t3_wr_rdata", 64'h0000_0000_0000_C0DE});
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("t3_wait%0d_stall", k), 64'(a_core_stall), 64'd0);
            next_cycle();
        end
        settle();
        chk("t3_grant_stall", 64'(a_core_stall), 64'd1);
        chk("t3_grant_we", 64'(a_mem_we), 64'd1);
        chk("t3_grant_wdata", a_mem_wdata, 64'h0000_0000_0000_D00D);
        next_cycle(); settle();
        chk("t3_ack_rdback", a_core_rdata, 64'h0000_0000_0000_D00D);
        chk("t3_ack_wdata", a_mem_wdata, 64'h0000_0000_0000_C0DE);
        chk("t3_ack_we", 64'(a_mem_we), 64'd1);
        next_cycle();
        core_req = 1'b0; core_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        next_cycle();
        core_req = 1'b1; core_addr = 5'd7;
        settle();
        chk("t3_final_mem7", a_core_rdata, 64'h0000_0000_0000_C0DE);

        // Back-to-back debug reads with dbg_req held, core idle.
        next_cycle();
        core_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [AW-1:0] ad;
            ad = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
            dbg_addr = ad;
            sb_q.push_back('{$sformatf("t4_rd%0d_rdata", i), pat(ad)});
            settle();
            chk($sformatf("t4_rd%0d_idle", i), 64'(a_busy), 64'd0);
            next_cycle(); settle();
            chk($sformatf("t4_rd%0d_addr", i), 64'(a_mem_addr), 64'(ad));
            next_cycle(); settle();
            chk($sformatf("t4_rd%0d_ack", i), 64'(a_dbg_ack), 64'd1);
            next_cycle();
        end
        dbg_req = 1'b0;

        // IDLE pass-through vectors.
        foreach (vecs[i]) begin
            next_cycle();
            core_req = vecs[i].req; core_we = vecs[i].we; core_ctrl = vecs[i].ctrl;
            core_addr = vecs[i].addr; core_wdata = vecs[i].wdata;
            settle();
            chk($sformatf("v%0d_we", i), 64'(a_mem_we), 64'(vecs[i].exp_we));
            chk($sformatf("v%0d_addr", i), 64'(a_mem_addr), 64'(vecs[i].addr));
            chk($sformatf("v%0d_ctrl", i), 64'(a_mem_ctrl), 64'(vecs[i].ctrl));
            chk($sformatf("v%0d_wdata", i), a_mem_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_rdata", i), a_core_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_stall", i), 64'(a_core_stall), 64'd0);
        end

        // Reset during DBG_GRANT aborts the transaction.
        next_cycle();
        core_req = 1'b0; core_we = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 64'h0000_0000_0000_0BAD;
        next_cycle();
        reset = 1'b1; core_req = 1'b1;
        settle();
        chk("t5_rst_grant_we", 64'(a_mem_we), 64'd0);
        next_cycle();
        reset = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        settle();
        chk("t5_ack", 64'(a_dbg_ack), 64'd0);
        chk("t5_rdata", a_dbg_rdata, 64'd0);
        chk("t5_stall", 64'(a_core_stall), 64'd0);
        chk("t5_busy", 64'(a_busy), 64'd0);

        // starve_limit=1: grant the cycle after the request despite core traffic.
        next_cycle();
        core_req = 1'b1; core_we = 1'b0; core_addr = 5'd0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd6;
        settle();
        chk("t6_n_busy", 64'(b_busy), 64'd0);
        chk("t6_n_stall", 64'(b_core_stall), 64'd0);
        next_cycle(); settle();
        chk("t6_grant_busy", 64'(b_busy), 64'd1);
        chk("t6_grant_stall", 64'(b_core_stall), 64'd1);
        chk("t6_grant_addr", 64'(b_mem_addr), 64'd6);
        chk("t6_a_nostall", 64'(a_core_stall), 64'd0);
        next_cycle(); settle();
        chk("t6_ack", 64'(b_dbg_ack), 64'd1);
        chk("t6_rdata", b_dbg_rdata, pat(5'd6));
        chk("t6_ack_stall", 64'(b_core_stall), 64'd0);
        next_cycle();
        dbg_req = 1'b0; core_req = 1'b0;

        repeat (4) next_cycle();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
